csr_trap_ctrl: RTL and testbench

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_trap_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap controller for a single-hart RISC-V core.
// Owns trap entry, mret return and the PC redirect handshake to fetch.
module csr_trap_ctrl #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     HART_ID     = 0,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_req_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            csr_rsp_valid,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] intr_pc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  typedef enum logic {
    S_IDLE,
    S_REDIRECT
  } state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] MISA =
    (XLEN'(1) << (XLEN-2)) | XLEN'(32'h0000_1100);

  state_t          r_state;
  state_t          w_next_state;

  logic            r_sts_mie;
  logic            r_sts_mpie;
  logic [1:0]      r_sts_mpp;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;

  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rdata;
  logic            r_illegal;
  logic [XLEN-1:0] r_redir_pc;

  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_wval;
  logic [XLEN-1:0] w_mtvec_new;
  logic            w_mapped;
  logic            w_ro;
  logic            w_do_write;
  logic            w_illegal;

  logic [2:0]      w_irq_vec;
  logic            w_irq_pend;
  logic [4:0]      w_irq_cause;

  logic            w_idle;
  logic            w_take_exc;
  logic            w_take_mret;
  logic            w_take_irq;
  logic            w_take_trap;
  logic            w_take_csr;
  logic            w_csr_wr;

  logic [4:0]      w_cause;
  logic [XLEN-1:0] w_trap_pc;
  logic [XLEN-1:0] w_mcause;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_vec_pc;

  always_comb begin
    w_mstatus        = '0;
    w_mstatus[3]     = r_sts_mie;
    w_mstatus[7]     = r_sts_mpie;
    w_mstatus[12:11] = r_sts_mpp;
    w_mip            = '0;
    w_mip[11]        = irq_ext;
    w_mip[7]         = irq_timer;
    w_mip[3]         = irq_sw;
  end

  always_comb begin
    w_old    = '0;
    w_mapped = 1'b1;
    w_ro     = 1'b0;
    unique case (csr_addr)
      12'h300: w_old = w_mstatus;
      12'h301: begin w_old = MISA; w_ro = 1'b1; end
      12'h304: w_old = r_mie;
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h343: w_old = r_mtval;
      12'h344: begin w_old = w_mip; w_ro = 1'b1; end
      12'hF11: w_ro = 1'b1;
      12'hF12: w_ro = 1'b1;
      12'hF13: w_ro = 1'b1;
      12'hF14: begin w_old = XLEN'(HART_ID); w_ro = 1'b1; end
      default: w_mapped = 1'b0;
    endcase
  end

  always_comb begin
    w_wval = w_old;
    unique case (csr_op)
      OP_RW:   w_wval = csr_wdata;
      OP_RS:   w_wval = w_old | csr_wdata;
      OP_RC:   w_wval = w_old & ~csr_wdata;
      default: w_wval = w_old;
    endcase
  end

  // Reserved mtvec modes (2/3) keep the previous mode.
  assign w_mtvec_new = {w_wval[XLEN-1:2],
                        w_wval[1] ? r_mtvec[1:0] : w_wval[1:0]};
  assign w_do_write  = (csr_op != 2'b00);
  assign w_illegal   = !w_mapped || (w_ro && w_do_write);

  assign w_irq_vec  = {r_mie[11] & irq_ext,
                       r_mie[7]  & irq_timer,
                       r_mie[3]  & irq_sw};
  assign w_irq_pend = r_sts_mie && (w_irq_vec != 3'b000);

  always_comb begin
    w_irq_cause = 5'd0;
    if (w_irq_vec[2])      w_irq_cause = 5'd11;
    else if (w_irq_vec[0]) w_irq_cause = 5'd3;
    else if (w_irq_vec[1]) w_irq_cause = 5'd7;
  end

  assign w_idle      = (r_state == S_IDLE);
  assign w_take_exc  = w_idle && exc_valid;
  assign w_take_mret = w_idle && !exc_valid && mret_valid;
  assign w_take_irq  = w_idle && !exc_valid && !mret_valid && w_irq_pend;
  assign w_take_trap = w_take_exc || w_take_irq;
  assign w_take_csr  = w_idle && !exc_valid && !mret_valid &&
                       !w_irq_pend && csr_req_valid;
  assign w_csr_wr    = w_take_csr && w_do_write && !w_illegal;

  always_comb begin
    w_cause             = w_take_exc ? exc_cause : w_irq_cause;
    w_trap_pc           = w_take_exc ? exc_pc : intr_pc;
    w_mcause            = XLEN'(w_cause);
    w_mcause[XLEN-1]    = w_take_irq;
    w_base              = {r_mtvec[XLEN-1:2], 2'b00};
    w_vec_pc            = w_base;
    if (w_take_irq && r_mtvec[1:0] == 2'b01)
      w_vec_pc = w_base + XLEN'({w_cause, 2'b00});
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:
        if (exc_valid || mret_valid || w_irq_pend)
          w_next_state = S_REDIRECT;
      S_REDIRECT:
        if (redirect_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    redirect_valid = (r_state == S_REDIRECT);
    redirect_pc    = r_redir_pc;
    csr_rsp_valid  = r_rsp_valid;
    csr_rdata      = r_rdata;
    csr_illegal    = r_illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redir_pc <= '0;
    end else if (w_take_trap) begin
      r_redir_pc <= w_vec_pc;
    end else if (w_take_mret) begin
      r_redir_pc <= r_mepc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_rsp_valid <= w_take_csr;
      r_illegal   <= w_take_csr && w_illegal;
      if (w_take_csr)
        r_rdata <= w_illegal ? '0 : w_old;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sts_mie  <= 1'b0;
      r_sts_mpie <= 1'b0;
      r_sts_mpp  <= 2'b11;
      r_mie      <= '0;
      r_mtvec    <= RESET_MTVEC;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (w_take_trap) begin
      r_mepc     <= w_trap_pc & PC_MASK;
      r_mcause   <= w_mcause;
      r_mtval    <= w_take_exc ? exc_tval : '0;
      r_sts_mpie <= r_sts_mie;
      r_sts_mie  <= 1'b0;
      r_sts_mpp  <= 2'b11;
    end else if (w_take_mret) begin
      r_sts_mie  <= r_sts_mpie;
      r_sts_mpie <= 1'b1;
      r_sts_mpp  <= 2'b11;
    end else if (w_csr_wr) begin
      case (csr_addr)
        12'h300: begin
          r_sts_mie  <= w_wval[3];
          r_sts_mpie <= w_wval[7];
          r_sts_mpp  <= w_wval[12:11];
        end
        12'h304: r_mie      <= w_wval;
        12'h305: r_mtvec    <= w_mtvec_new;
        12'h340: r_mscratch <= w_wval;
        12'h341: r_mepc     <= w_wval & PC_MASK;
        12'h342: r_mcause   <= w_wval;
        12'h343: r_mtval    <= w_wval;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed self-checking bench for csr_trap_ctrl.
// Each task drives one scenario and compares against hand-computed values.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_req_valid = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] csr_wdata = 32'h0;
  logic        csr_rsp_valid;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_cause = 5'd0;
  logic [31:0] exc_pc = 32'h0;
  logic [31:0] exc_tval = 32'h0;
  logic        mret_valid = 1'b0;
  logic [31:0] intr_pc = 32'h0;
  logic        irq_ext = 1'b0;
  logic        irq_timer = 1'b0;
  logic        irq_sw = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  logic        ill;
  logic        vld;

  csr_trap_ctrl #(
    .XLEN        (32),
    .HART_ID     (3),
    .RESET_MTVEC (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr_req_valid  (csr_req_valid),
    .csr_op         (csr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rsp_valid  (csr_rsp_valid),
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret_valid     (mret_valid),
    .intr_pc        (intr_pc),
    .irq_ext        (irq_ext),
    .irq_timer      (irq_timer),
    .irq_sw         (irq_sw),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic csr_xfer(
    input  logic [1:0]  op,
    input  logic [11:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] o_rd,
    output logic        o_ill,
    output logic        o_vld
  );
    @(negedge clk);
    csr_req_valid = 1'b1;
    csr_op        = op;
    csr_addr      = addr;
    csr_wdata     = wd;
    @(posedge clk);
    #1;
    o_vld = csr_rsp_valid;
    o_rd  = csr_rdata;
    o_ill = csr_illegal;
    csr_req_valid = 1'b0;
  endtask

  task automatic release_redirect();
    redirect_ready = 1'b1;
    @(posedge clk);
    #1;
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (redirect_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_redirect_valid: got %b want 0", redirect_valid);
    end
    n_checks++;
    if ({csr_rsp_valid, csr_illegal, csr_rdata} !== 34'h0) begin
      n_errors++;
      $display("FAIL rst_rsp: got %b %b %h want 0 0 0",
               csr_rsp_valid, csr_illegal, csr_rdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    csr_xfer(2'b00, 12'h300, 32'h0, rd, ill, vld);
    n_checks++;
    if ({vld, ill, rd} !== {2'b10, 32'h0000_1800}) begin
      n_errors++;
      $display("FAIL rst_mstatus: got %b %b %h want 1 0 00001800",
               vld, ill, rd);
    end
    csr_xfer(2'b00, 12'h305, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_0100) begin
      n_errors++;
      $display("FAIL rst_mtvec: got %h want 00000100", rd);
    end
    csr_xfer(2'b00, 12'h301, 32'h0, rd, ill, vld);
    n_checks++;
    if ({ill, rd} !== {1'b0, 32'h4000_1100}) begin
      n_errors++;
      $display("FAIL misa: got %b %h want 0 40001100", ill, rd);
    end
    csr_xfer(2'b00, 12'hF14, 32'h0, rd, ill, vld);
    n_checks++;
    if ({ill, rd} !== {1'b0, 32'h3}) begin
      n_errors++;
      $display("FAIL mhartid: got %b %h want 0 00000003", ill, rd);
    end
    csr_xfer(2'b00, 12'hF11, 32'h0, rd, ill, vld);
    n_checks++;
    if ({ill, rd} !== {1'b0, 32'h0}) begin
      n_errors++;
      $display("FAIL mvendorid: got %b %h want 0 00000000", ill, rd);
    end
  endtask

  task automatic test_csr_rw_rs();
    csr_xfer(2'b01, 12'h340, 32'hDEAD_BEEF, rd, ill, vld);
    n_checks++;
    if ({vld, ill, rd} !== {2'b10, 32'h0}) begin
      n_errors++;
      $display("FAIL rw_old: got %b %b %h want 1 0 00000000", vld, ill, rd);
    end
    n_checks++;
    @(posedge clk);
    #1;
    if (csr_rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rsp_pulse: got %b want 0", csr_rsp_valid);
    end
    csr_xfer(2'b10, 12'h340, 32'h0000_0010, rd, ill, vld);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL rs_old: got %h want deadbeef", rd);
    end
    csr_xfer(2'b00, 12'h340, 32'hFFFF_FFFF, rd, ill, vld);
    n_checks++;
    if (rd !== 32'hDEAD_BEFF) begin
      n_errors++;
      $display("FAIL rs_new: got %h want deadbeff", rd);
    end
    csr_xfer(2'b11, 12'h340, 32'h0000_00F0, rd, ill, vld);
    csr_xfer(2'b01, 12'h340, 32'hDEAD_BEFF, rd, ill, vld);
    n_checks++;
    if (rd !== 32'hDEAD_BE0F) begin
      n_errors++;
      $display("FAIL rc_new: got %h want deadbe0f", rd);
    end
  endtask

  task automatic test_exception();
    csr_xfer(2'b01, 12'h305, 32'h0000_1000, rd, ill, vld);
    csr_xfer(2'b10, 12'h300, 32'h0000_0008, rd, ill, vld);
    @(negedge clk);
    exc_valid = 1'b1;
    exc_cause = 5'd2;
    exc_pc    = 32'h8000_0102;
    exc_tval  = 32'h0000_1234;
    @(posedge clk);
    #1;
    exc_valid = 1'b0;
    n_checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0000_1000}) begin
      n_errors++;
      $display("FAIL exc_redirect: got %b %h want 1 00001000",
               redirect_valid, redirect_pc);
    end
    release_redirect();
    n_checks++;
    if (redirect_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL exc_release: got %b want 0", redirect_valid);
    end
    csr_xfer(2'b00, 12'h341, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h8000_0100) begin
      n_errors++;
      $display("FAIL exc_mepc: got %h want 80000100", rd);
    end
    csr_xfer(2'b00, 12'h342, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_0002) begin
      n_errors++;
      $display("FAIL exc_mcause: got %h want 00000002", rd);
    end
    csr_xfer(2'b00, 12'h343, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_1234) begin
      n_errors++;
      $display("FAIL exc_mtval: got %h want 00001234", rd);
    end
    csr_xfer(2'b00, 12'h300, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_1880) begin
      n_errors++;
      $display("FAIL exc_mstatus: got %h want 00001880", rd);
    end
  endtask

  task automatic test_interrupt_vectored();
    csr_xfer(2'b01, 12'h305, 32'h0000_2001, rd, ill, vld);
    csr_xfer(2'b10, 12'h300, 32'h0000_0008, rd, ill, vld);
    csr_xfer(2'b01, 12'h304, 32'h0000_0888, rd, ill, vld);
    intr_pc = 32'h0000_0456;
    @(negedge clk);
    irq_timer = 1'b1;
    irq_ext   = 1'b1;
    @(posedge clk);
    #1;
    irq_timer = 1'b0;
    irq_ext   = 1'b0;
    n_checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0000_202C}) begin
      n_errors++;
      $display("FAIL irq_redirect: got %b %h want 1 0000202c",
               redirect_valid, redirect_pc);
    end
    release_redirect();
    csr_xfer(2'b00, 12'h342, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h8000_000B) begin
      n_errors++;
      $display("FAIL irq_mcause: got %h want 8000000b", rd);
    end
    csr_xfer(2'b00, 12'h341, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_0454) begin
      n_errors++;
      $display("FAIL irq_mepc: got %h want 00000454", rd);
    end
    csr_xfer(2'b00, 12'h343, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL irq_mtval: got %h want 00000000", rd);
    end
    csr_xfer(2'b00, 12'h300, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_1880) begin
      n_errors++;
      $display("FAIL irq_mstatus: got %h want 00001880", rd);
    end
  endtask

  task automatic test_backpressure_mret();
    csr_xfer(2'b10, 12'h300, 32'h0000_0008, rd, ill, vld);
    redirect_ready = 1'b0;
    @(negedge clk);
    exc_valid = 1'b1;
    exc_cause = 5'd5;
    exc_pc    = 32'h0000_0300;
    exc_tval  = 32'h0;
    @(posedge clk);
    #1;
    exc_cause = 5'd7;
    exc_pc    = 32'h0000_0999;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0000_2000}) begin
        n_errors++;
        $display("FAIL hold_%0d: got %b %h want 1 00002000",
                 i, redirect_valid, redirect_pc);
      end
      @(posedge clk);
      #1;
    end
    exc_valid = 1'b0;
    release_redirect();
    n_checks++;
    if (redirect_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_release: got %b want 0", redirect_valid);
    end
    csr_xfer(2'b00, 12'h341, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_0300) begin
      n_errors++;
      $display("FAIL hold_mepc: got %h want 00000300", rd);
    end
    csr_xfer(2'b00, 12'h342, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_0005) begin
      n_errors++;
      $display("FAIL hold_mcause: got %h want 00000005", rd);
    end
    @(negedge clk);
    mret_valid = 1'b1;
    @(posedge clk);
    #1;
    mret_valid = 1'b0;
    n_checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0000_0300}) begin
      n_errors++;
      $display("FAIL mret_redirect: got %b %h want 1 00000300",
               redirect_valid, redirect_pc);
    end
    release_redirect();
    csr_xfer(2'b00, 12'h300, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_1888) begin
      n_errors++;
      $display("FAIL mret_mstatus: got %h want 00001888", rd);
    end
  endtask

  task automatic test_illegal_warl();
    csr_xfer(2'b01, 12'h344, 32'h0000_0FFF, rd, ill, vld);
    n_checks++;
    if ({vld, ill} !== 2'b11) begin
      n_errors++;
      $display("FAIL ill_mip_wr: got %b %b want 1 1", vld, ill);
    end
    csr_xfer(2'b10, 12'h301, 32'hFFFF_FFFF, rd, ill, vld);
    n_checks++;
    if ({vld, ill} !== 2'b11) begin
      n_errors++;
      $display("FAIL ill_misa_wr: got %b %b want 1 1", vld, ill);
    end
    csr_xfer(2'b00, 12'h7C0, 32'h0, rd, ill, vld);
    n_checks++;
    if ({vld, ill} !== 2'b11) begin
      n_errors++;
      $display("FAIL ill_unmapped: got %b %b want 1 1", vld, ill);
    end
    csr_xfer(2'b00, 12'h340, 32'h0, rd, ill, vld);
    n_checks++;
    if ({ill, rd} !== {1'b0, 32'hDEAD_BEFF}) begin
      n_errors++;
      $display("FAIL ill_nochange: got %b %h want 0 deadbeff", ill, rd);
    end
    csr_xfer(2'b01, 12'h305, 32'h0000_5003, rd, ill, vld);
    csr_xfer(2'b00, 12'h305, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_5001) begin
      n_errors++;
      $display("FAIL warl_mtvec: got %h want 00005001", rd);
    end
    csr_xfer(2'b01, 12'h341, 32'h0000_0ABF, rd, ill, vld);
    csr_xfer(2'b00, 12'h341, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_0ABC) begin
      n_errors++;
      $display("FAIL warl_mepc: got %h want 00000abc", rd);
    end
    csr_xfer(2'b11, 12'h300, 32'h0000_0008, rd, ill, vld);
    @(negedge clk);
    irq_sw  = 1'b1;
    irq_ext = 1'b1;
    csr_xfer(2'b00, 12'h344, 32'h0, rd, ill, vld);
    irq_sw  = 1'b0;
    irq_ext = 1'b0;
    n_checks++;
    if ({vld, ill, rd} !== {2'b10, 32'h0000_0808}) begin
      n_errors++;
      $display("FAIL mip_read: got %b %b %h want 1 0 00000808",
               vld, ill, rd);
    end
  endtask

  task automatic test_priority_drop();
    @(negedge clk);
    exc_valid     = 1'b1;
    exc_cause     = 5'd3;
    exc_pc        = 32'h0000_0040;
    exc_tval      = 32'h0;
    csr_req_valid = 1'b1;
    csr_op        = 2'b01;
    csr_addr      = 12'h340;
    csr_wdata     = 32'h0000_1111;
    @(posedge clk);
    #1;
    exc_valid     = 1'b0;
    csr_req_valid = 1'b0;
    n_checks++;
    if (csr_rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_rsp: got %b want 0", csr_rsp_valid);
    end
    n_checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0000_5000}) begin
      n_errors++;
      $display("FAIL drop_redirect: got %b %h want 1 00005000",
               redirect_valid, redirect_pc);
    end
    release_redirect();
    csr_xfer(2'b00, 12'h340, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'hDEAD_BEFF) begin
      n_errors++;
      $display("FAIL drop_mscratch: got %h want deadbeff", rd);
    end
    csr_xfer(2'b00, 12'h342, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_0003) begin
      n_errors++;
      $display("FAIL drop_mcause: got %h want 00000003", rd);
    end
  endtask

  task automatic test_reset_in_redirect();
    @(negedge clk);
    exc_valid = 1'b1;
    exc_cause = 5'd1;
    exc_pc    = 32'h0000_0080;
    exc_tval  = 32'h0000_0077;
    @(posedge clk);
    #1;
    exc_valid = 1'b0;
    n_checks++;
    if (redirect_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rr_enter: got %b want 1", redirect_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (redirect_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rr_async: got %b want 0", redirect_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    csr_xfer(2'b00, 12'h300, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_1800) begin
      n_errors++;
      $display("FAIL rr_mstatus: got %h want 00001800", rd);
    end
    csr_xfer(2'b00, 12'h305, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0000_0100) begin
      n_errors++;
      $display("FAIL rr_mtvec: got %h want 00000100", rd);
    end
    csr_xfer(2'b00, 12'h304, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL rr_mie: got %h want 00000000", rd);
    end
    csr_xfer(2'b00, 12'h340, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL rr_mscratch: got %h want 00000000", rd);
    end
    csr_xfer(2'b00, 12'h341, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL rr_mepc: got %h want 00000000", rd);
    end
    csr_xfer(2'b00, 12'h342, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL rr_mcause: got %h want 00000000", rd);
    end
    csr_xfer(2'b00, 12'h343, 32'h0, rd, ill, vld);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL rr_mtval: got %h want 00000000", rd);
    end
    n_checks++;
    if (redirect_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rr_idle: got %b want 0", redirect_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_csr_rw_rs();
    test_exception();
    test_interrupt_vectored();
    test_backpressure_mret();
    test_illegal_warl();
    test_priority_drop();
    test_reset_in_redirect();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
